axi_lite_req_arbiter: RTL and testbench
=======================================

Name: axi_lite_req_arbiter

Overview:
- Shares one AXI-lite manager port among NUM_REQ local requesters. Each requester presents a single-beat read or write command.
- A round-robin arbiter grants one command at a time. The block drives the AW/W/B or AR/R channels and returns the response to the granted requester.
- Sits between register-access clients (test sequencers, config engines) and the FIFO's AXI-lite subordinate.
- Only one transaction is outstanding at any time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, AXI data width.
- ADDR_WIDTH, 8, AXI address width.

Ports:
- m_axi_clk  in  1  clock.
- m_axi_resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- busy  out  1  high whenever state is not IDLE.
- err_count  out  8  saturating count of non-OKAY responses.
- m_axi_awaddr/awvalid out, m_axi_awready in: AW channel.
- m_axi_wdata/wvalid out, m_axi_wready in: W channel.
- m_axi_bresp[1:0]/bvalid in, m_axi_bready out: B channel.
- m_axi_araddr/arvalid out, m_axi_arready in: AR channel.
- m_axi_rdata/rresp[1:0]/rvalid in, m_axi_rready out: R channel.

Behaviour:
- Reset values:
  - State IDLE; all AXI valids/readies 0.
  - awaddr/araddr/wdata 0; rsp_valid 0; rsp_rdata 0; rsp_resp 0; busy 0; err_count 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching from last_grant+1 upward modulo NUM_REQ.
  - req_ready is combinational: one-hot at the granted index, only in IDLE, only when that req_valid=1.
  - On acceptance, latch the command and index and set last_grant to that index.
  - Next state is WR_ADDR if write, else RD_ADDR.
  - Ungranted requesters must hold req_valid and their command.
- WR_ADDR:
  - awvalid and wvalid both rise on entry.
  - Each falls independently after its own handshake; they are never reasserted within the transaction.
  - bready = 1 throughout WR_ADDR and WR_RESP.
  - Go to WR_RESP when both handshakes are complete; same-cycle completion of both goes directly.
- WR_RESP: on bvalid&&bready, latch bresp, rdata := 0, go to DONE.
- RD_ADDR: arvalid = 1 until the arready handshake, then RD_RESP. rready = 1 throughout RD_ADDR and RD_RESP.
- RD_RESP: on rvalid&&rready, latch rdata/rresp, go to DONE.
- DONE:
  - rsp_valid[granted] = 1 for exactly one cycle; rsp_rdata/rsp_resp are valid that cycle and held until the next DONE.
  - err_count increments if resp != 0, saturating at 255.
  - Return to IDLE.
  - Requesters cannot back-pressure the response.
- Latency, with an always-ready subordinate:
  - Accept at cycle T; AW/W or AR valid at T+1; B/R at T+2 earliest; rsp_valid at T+3.
  - Earliest next acceptance is T+4.
- Back-to-back requests: with all requesters valid continuously, grants rotate 0,1,..,N-1,0. No requester is starved, and each waits at most NUM_REQ-1 transactions.
- A B or R handshake outside the matching RESP/ADDR states is impossible, because bready/rready are 0 elsewhere.
- Reset asserted mid-transaction:
  - All outputs return immediately to reset values; the in-flight transaction is abandoned and no rsp_valid is issued.
  - Requesters must re-issue after reset.
- busy = 1 in every state other than IDLE.

Test Plan:
- Single write, req 0: addr 0x04, data 0xA5, subordinate always ready, bresp=0 -> awaddr=0x04 and wdata=0xA5 at T+1; rsp_valid=2'b01 at T+3 with rsp_resp=0 and rsp_rdata=0.
- Single read, req 1: addr 0x08, subordinate returns rdata 0x3C, rresp=0 -> rsp_valid=2'b10 with rsp_rdata=0x3C; err_count stays 0.
- Both requesters valid continuously for 6 transactions -> grant order 0,1,0,1,0,1; req_ready is never high for both in the same cycle.
- Subordinate holds awready low 3 cycles, wready high -> wvalid drops after 1 cycle, awvalid held 3 cycles; single B; one rsp_valid pulse.
- Subordinate returns bresp=2'b10 on 300 consecutive writes -> rsp_resp=2'b10 each time; err_count saturates at 255.
- Reset pulsed while in WR_RESP -> awvalid/wvalid/bready/busy 0 immediately; no rsp_valid; the next request is granted to requester 0.

Source files
------------

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI-lite manager port among NUM_REQ single-beat
// requesters; one transaction outstanding, response returned as a one-cycle pulse.
module axi_lite_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            m_axi_clk,
  input  logic                            m_axi_resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic [7:0]                      err_count,
  output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [DATA_WIDTH-1:0]           m_axi_wdata,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                  state_q, state_d;
  logic [IW-1:0]           last_grant_q, last_grant_d;
  logic [IW-1:0]           gnt_q, gnt_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [7:0]              err_count_q, err_count_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic                    gnt_found;
  logic [IW-1:0]           gnt_idx;
  logic [IW-1:0]           cand;
  logic                    accept;
  logic                    aw_hs, w_hs;
  logic                    done_now;
  logic [DATA_WIDTH-1:0]   done_data;
  logic [1:0]              done_resp;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept = (state_q == IDLE) && gnt_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q && m_axi_wready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    err_count_d  = err_count_q;
    done_now     = 1'b0;
    done_data    = '0;
    done_resp    = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = gnt_idx;
          gnt_d        = gnt_idx;
          if (req_write[gnt_idx]) begin
            state_d   = WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            awaddr_d  = addr_arr[gnt_idx];
            wdata_d   = wdata_arr[gnt_idx];
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = addr_arr[gnt_idx];
          end
        end
      end
      WR_ADDR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // AW and W complete independently; leave once both have been taken.
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d  = 1'b0;
          done_now  = 1'b1;
          done_resp = m_axi_bresp;
        end
      end
      RD_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d  = 1'b0;
          done_now  = 1'b1;
          done_data = m_axi_rdata;
          done_resp = m_axi_rresp;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The response pulse is registered, so it is high exactly while in DONE.
    if (done_now) begin
      state_d            = DONE;
      rsp_valid_d[gnt_q] = 1'b1;
      rsp_rdata_d        = done_data;
      rsp_resp_d         = done_resp;
      if (done_resp != 2'b00) err_count_d = sat_inc(err_count_q);
    end
  end

  always_ff @(posedge m_axi_clk or negedge m_axi_resetn) begin
    if (!m_axi_resetn) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      gnt_q        <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
      err_count_q  <= err_count_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign err_count     = err_count_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter with two requesters and a small
// reactive AXI-lite subordinate whose readiness and responses are set per test.
module tb_axi_lite_req_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [7:0]  err_count;
  logic [7:0]  awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  logic        b_hold;
  logic        aw_got, w_got;
  int          b_cnt;
  int          n_chk, n_fail;

  axi_lite_req_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .m_axi_clk(clk), .m_axi_resetn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .err_count(err_count),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subordinate: B follows both AW and W, R follows AR, at the earliest one cycle later.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid && !b_hold) begin
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready)   w_got  <= 1'b1;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_cnt  <= b_cnt + 1;
      end
      if (arvalid && arready) rvalid <= 1'b1;
      if (rvalid && rready)   rvalid <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic idx, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    req_write[idx] = wr;
    if (idx) begin
      req_addr[15:8]  = addr;
      req_wdata[15:8] = data;
    end else begin
      req_addr[7:0]  = addr;
      req_wdata[7:0] = data;
    end
  endtask

  // One request from one requester; reports T+1 address, response fields and latency.
  task automatic do_txn(input logic idx, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        output logic [7:0] a1, output logic [1:0] v, output logic [7:0] rd,
                        output logic [1:0] rs, output int lat);
    bit got;
    v = 2'b00; rd = 8'h00; rs = 2'b00; a1 = 8'h00; lat = 0; got = 1'b0;
    @(negedge clk);
    set_cmd(idx, wr, addr, data);
    req_valid[idx] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (req_ready[idx]) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check_eq("grant_timeout", 0, 1);
      req_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
    @(negedge clk);
    a1  = wr ? awaddr : araddr;
    lat = 1;
    for (int c = 0; c < 50 && v == 2'b00; c++) begin
      if (rsp_valid != 2'b00) begin
        v  = rsp_valid;
        rd = rsp_rdata;
        rs = rsp_resp;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (v == 2'b00) check_eq("rsp_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] a1, rd;
    logic [1:0] v, rs;
    int lat, ng, aw_cyc, w_cyc, rsp_cnt, b0;
    int grants[6];
    logic both, rsp_seen;
    logic [1:0] rsp_last;

    n_chk = 0; n_fail = 0; b_cnt = 0;
    rstn = 1'b0; b_hold = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bresp = 2'b00; rresp = 2'b00; rdata = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_awvalid", 32'(awvalid), 0);
    check_eq("rst_wvalid", 32'(wvalid), 0);
    check_eq("rst_arvalid", 32'(arvalid), 0);
    check_eq("rst_readies", 32'({bready, rready}), 0);
    check_eq("rst_addrs", 32'({awaddr, araddr, wdata}), 0);
    check_eq("rst_rsp", 32'({rsp_valid, rsp_rdata, rsp_resp}), 0);
    check_eq("rst_err", 32'(err_count), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single write from requester 0, cycle by cycle.
    set_cmd(1'b0, 1'b1, 8'h04, 8'hA5);
    req_valid = 2'b01;
    #1 check_eq("wr_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check_eq("wr_t1_awvalid", 32'(awvalid), 1);
    check_eq("wr_t1_awaddr", 32'(awaddr), 32'h04);
    check_eq("wr_t1_wvalid", 32'(wvalid), 1);
    check_eq("wr_t1_wdata", 32'(wdata), 32'hA5);
    check_eq("wr_t1_bready_busy", 32'({bready, busy}), 32'h3);
    @(negedge clk);
    check_eq("wr_t2_valids", 32'({awvalid, wvalid}), 0);
    check_eq("wr_t2_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    check_eq("wr_t3_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("wr_t3_rsp_resp", 32'(rsp_resp), 0);
    check_eq("wr_t3_rsp_rdata", 32'(rsp_rdata), 0);
    @(negedge clk);
    check_eq("wr_t4_rsp_valid", 32'(rsp_valid), 0);
    check_eq("wr_t4_busy", 32'(busy), 0);

    // Single read from requester 1.
    rdata = 8'h3C; rresp = 2'b00;
    do_txn(1'b1, 1'b0, 8'h08, 8'h00, a1, v, rd, rs, lat);
    check_eq("rd_araddr", 32'(a1), 32'h08);
    check_eq("rd_rsp_valid", 32'(v), 32'h2);
    check_eq("rd_rdata", 32'(rd), 32'h3C);
    check_eq("rd_resp", 32'(rs), 0);
    check_eq("rd_latency", 32'(lat), 3);
    check_eq("rd_err", 32'(err_count), 0);

    // Both requesters continuously valid: grants must alternate.
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 8'h10, 8'h11);
    set_cmd(1'b1, 1'b0, 8'h20, 8'h00);
    req_valid = 2'b11;
    ng = 0; both = 1'b0;
    for (int c = 0; c < 200 && ng < 6; c++) begin
      #1;
      if (req_ready == 2'b11) both = 1'b1;
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready[1] ? 1 : 0;
        ng++;
        if (ng == 6) begin
          @(posedge clk);
          #1 req_valid = 2'b00;
        end
      end
      @(negedge clk);
    end
    check_eq("rr_count", 32'(ng), 6);
    for (int i = 0; i < 6; i++) check_eq("rr_grant", 32'(grants[i]), 32'(i % 2));
    check_eq("rr_never_both", 32'(both), 0);
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check_eq("rr_drain", 32'(busy), 0);

    // AW stalled: W taken at once, AW held three cycles.
    @(negedge clk);
    awready = 1'b0;
    set_cmd(1'b0, 1'b1, 8'h30, 8'h55);
    req_valid = 2'b01;
    b0 = b_cnt;
    #1 check_eq("stall_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    aw_cyc = 0; w_cyc = 0; rsp_cnt = 0; rsp_last = 2'b00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (rsp_valid != 2'b00) begin
        rsp_cnt++;
        rsp_last = rsp_valid;
      end
      if (c == 3) awready = 1'b1;
    end
    check_eq("stall_aw_cycles", 32'(aw_cyc), 3);
    check_eq("stall_w_cycles", 32'(w_cyc), 1);
    check_eq("stall_b_count", 32'(b_cnt - b0), 1);
    check_eq("stall_rsp_count", 32'(rsp_cnt), 1);
    check_eq("stall_rsp_onehot", 32'(rsp_last), 32'h1);

    // 300 writes answered SLVERR: counter saturates.
    bresp = 2'b10;
    for (int i = 0; i < 300; i++) begin
      do_txn(1'b1, 1'b1, 8'h40, i[7:0], a1, v, rd, rs, lat);
      check_eq("err_rsp_resp", 32'(rs), 32'h2);
      if (i == 253) check_eq("err_count_254", 32'(err_count), 254);
    end
    check_eq("err_count_sat", 32'(err_count), 255);
    bresp = 2'b00;

    // Reset while waiting for B.
    b_hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    set_cmd(1'b1, 1'b1, 8'h50, 8'h66);
    req_valid = 2'b10;
    #1 check_eq("rst_mid_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mid_in_wr_resp", 32'({busy, bready, awvalid, wvalid}), 32'hC);
    rstn = 1'b0;
    #1;
    check_eq("rst_mid_valids", 32'({awvalid, wvalid, bready}), 0);
    check_eq("rst_mid_busy", 32'(busy), 0);
    check_eq("rst_mid_err", 32'(err_count), 0);
    rsp_seen = (rsp_valid != 2'b00);
    b_hold = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) rsp_seen = 1'b1;
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) rsp_seen = 1'b1;
    end
    check_eq("rst_mid_no_rsp", 32'(rsp_seen), 0);
    set_cmd(1'b0, 1'b0, 8'h60, 8'h00);
    set_cmd(1'b1, 1'b0, 8'h70, 8'h00);
    req_valid = 2'b11;
    #1 check_eq("rst_mid_next_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check_eq("rst_mid_drain", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
